// File: rtl/demux_sched_pkg.sv
// demux_sched_pkg: shared types and constants for the 8-lane demux scheduler.
// Holds the FSM state enum, lane count, select width and statistics width.
package demux_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEEK = 2'd1,
      XFER = 2'd2
   } state_e;

   localparam int NLANE = 8;
   localparam int SELW  = 3;
   localparam int STATW = 16;

endpackage

// File: rtl/demux_8_scheduler_pick.sv
// rr_lane_pick: combinational round-robin lane picker.
// Ports: lane_en_i (eligible lanes), cur_i (current lane),
//        nxt_o (first enabled lane after cur_i, wrapping), any_o (|lane_en_i).
module rr_lane_pick
   import demux_sched_pkg::*;
(
   input  logic [NLANE-1:0] lane_en_i,
   input  logic [SELW-1:0]  cur_i,
   output logic [SELW-1:0]  nxt_o,
   output logic             any_o
);

   logic [SELW-1:0] idx;

   // Scan from the farthest candidate (cur itself) toward cur+1 so that
   // the last hit, i.e. the nearest lane after cur, wins.
   always_comb begin
      nxt_o = cur_i;
      any_o = |lane_en_i;
      idx   = cur_i;
      for (int i = NLANE; i >= 1; i--) begin
         idx = cur_i + SELW'(i);
         if (lane_en_i[idx]) begin
            nxt_o = idx;
         end
      end
   end

endmodule

// File: rtl/demux_8_scheduler.sv
// demux_8_scheduler: round-robin scheduler sequencing a 1-to-8 demux.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data upstream;
//        lane_en, out_ready per lane; out_valid (one-hot), out_data, sel,
//        demux_en, busy. Optional DEMUX_SCHED_STATS_EN adds stat_sel and
//        stat_count (per-lane delivered-item counters, combinational read).
module demux_8_scheduler
   import demux_sched_pkg::*;
#(
   parameter int W     = 1,
   parameter int BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   input  logic [NLANE-1:0] lane_en,
   input  logic [NLANE-1:0] out_ready,
   output logic [NLANE-1:0] out_valid,
   output logic [W-1:0]     out_data,
   output logic [SELW-1:0]  sel,
   output logic             demux_en,
`ifdef DEMUX_SCHED_STATS_EN
   input  logic [SELW-1:0]  stat_sel,
   output logic [STATW-1:0] stat_count,
`endif
   output logic             busy
);

   localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [BW-1:0] LAST = BW'(BURST - 1);

   state_e          state_q;
   logic [SELW-1:0] cur_q;
   logic [BW-1:0]   burst_cnt_q;
   logic            hold_valid_q;
   logic [W-1:0]    hold_data_q;

   logic [SELW-1:0] nxt;
   logic            any_en;
   logic            presenting;
   logic            drain;
   logic            accept;

   rr_lane_pick u_pick (
      .lane_en_i (lane_en),
      .cur_i     (cur_q),
      .nxt_o     (nxt),
      .any_o     (any_en)
   );

   assign presenting = (state_q == XFER) && hold_valid_q && lane_en[cur_q];
   assign drain      = presenting && out_ready[cur_q];
   // Nothing is accepted while reset is asserted; it would be discarded.
   assign in_ready   = !rst && (!hold_valid_q || drain);
   assign accept     = in_valid && in_ready;

   always_comb begin
      out_valid        = '0;
      out_valid[cur_q] = presenting;
   end

   assign out_data = hold_data_q;
   assign sel      = cur_q;
   assign demux_en = presenting;
   assign busy     = (state_q != IDLE) || hold_valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cur_q        <= SELW'(NLANE - 1);
         burst_cnt_q  <= '0;
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
      end else begin
         // Accept wins over drain so back-to-back items need no bubble.
         if (accept) begin
            hold_valid_q <= 1'b1;
            hold_data_q  <= in_data;
         end else if (drain) begin
            hold_valid_q <= 1'b0;
         end

         unique case (state_q)
            IDLE: begin
               if (any_en) state_q <= SEEK;
            end
            SEEK: begin
               if (any_en) begin
                  cur_q       <= nxt;
                  burst_cnt_q <= '0;
                  state_q     <= XFER;
               end else begin
                  state_q <= IDLE;
               end
            end
            XFER: begin
               if (drain) begin
                  burst_cnt_q <= burst_cnt_q + BW'(1);
                  if (burst_cnt_q == LAST) state_q <= SEEK;
               end else if (!lane_en[cur_q]) begin
                  // Lane dropped out: keep the item for the next lane.
                  state_q <= SEEK;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef DEMUX_SCHED_STATS_EN
   logic [STATW-1:0] stat_q [NLANE];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NLANE; i++) stat_q[i] <= '0;
      end else if (drain) begin
         stat_q[cur_q] <= stat_q[cur_q] + STATW'(1);
      end
   end

   assign stat_count = stat_q[stat_sel];
`endif

endmodule

// File: doc/demux_8_scheduler.md
# demux_8_scheduler

Round-robin scheduler that sequences a 1-to-8 demultiplexer. It accepts a single input stream with a valid/ready handshake and holds each item in a register. It delivers BURST items to one enabled output lane before rotating to the next enabled lane. It drives the demux select (sel) and enable (demux_en) lines directly and sits between the upstream source and the 8-way demux fabric.

## Interface
- W, 1: data width in bits.
- BURST, 4: items delivered per lane visit. Range 1..16.

Ports:
- clk  in  1  single system clock; all logic is rising-edge.
- rst  in  1  reset; synchronous and active-high.
- in_valid  in  1  source has an item.
- in_ready  out  1  scheduler accepts the item this cycle.
- in_data  in  W  source item.
- lane_en  in  8  per-lane enable mask; bit i set means lane i is eligible.
- out_ready  in  8  per-lane sink ready.
- out_valid  out  8  one-hot or zero; bit cur is set when an item is presented to lane cur.
- out_data  out  W  held item, shared by all lanes.
- sel  out  3  current lane index; sel[0] drives demux s1, sel[1] drives s2, sel[2] drives s3.
- demux_en  out  1  equals |out_valid.
- busy  out  1  high whenever state is not IDLE or hold_valid is set.

## Operation
- State machine has three states: IDLE, SEEK and XFER. Registers:
  - cur: 3 bits.
  - burst_cnt: clog2(BURST) bits, minimum 1.
  - hold_valid and hold_data.
- Reset values:
  - state = IDLE, cur = 7, burst_cnt = 0, hold_valid = 0, hold_data = 0.
  - All outputs are 0, except sel = 7.
- Input accept:
  - in_ready = !hold_valid || drain, where drain = out_valid[cur] && out_ready[cur].
  - An accept is allowed in any state. Accept and drain in the same cycle load the new item with no bubble.
- IDLE:
  - If lane_en != 0, go to SEEK. Otherwise stay in IDLE.
  - An item may still be held while in IDLE.
- SEEK (exactly 1 cycle):
  - cur becomes the first set bit of lane_en, scanning (cur+1) mod 8 upward with wrap-around.
  - burst_cnt resets to 0 and the state goes to XFER.
  - If lane_en == 0, go to IDLE and leave cur unchanged.
- XFER:
  - out_valid[cur] = hold_valid && lane_en[cur]. On each drain, burst_cnt increments.
  - A drain with burst_cnt == BURST-1 goes to SEEK.
  - If lane_en[cur] deasserts with no drain in that cycle, go to SEEK. The held item is kept and delivered to the next lane.
  - With hold_valid == 0, XFER waits and the burst is not consumed.
- out_valid is never asserted outside XFER. An item presented to a lane stays stable until drained: out_data and cur do not change while out_valid is high.

## Timing
- Accept in cycle N leads to out_valid in cycle N+1 at the earliest, because out_valid is registered.
- Each lane switch costs 1 SEEK bubble. With a continuously ready sink, throughput is BURST/(BURST+1) items per cycle.
- sel and demux_en are valid in the same cycle as out_valid.
- A single enabled lane still passes through SEEK between bursts and re-selects itself.
- rst asserted mid-burst wins over all other activity. The held item is discarded and the block returns to reset values on the next edge.

## Configuration
- DEMUX_SCHED_STATS_EN defined adds per-lane statistics:
  - Eight 16-bit delivered-item counters that increment on drain and wrap at 0xFFFF to 0.
  - Read port: stat_sel (input, 3 bits) and stat_count (output, 16 bits). The read is combinational.
  - Counters clear on rst.
- Without DEMUX_SCHED_STATS_EN, stat_sel and stat_count do not exist and there are no counters.

## Structure
- Shared package demux_sched_pkg contains:
  - The state enum (IDLE, SEEK, XFER).
  - The lane count constant (8) and the select width constant (3).
  - The statistics counter width (16).
- One sub-module, rr_lane_pick: combinational.
  - Inputs: lane_en and cur.
  - Outputs: next lane index and an any-enabled flag.

## Test plan
- Reset with lane_en=8'hFF, BURST=4, all out_ready high, and 12 items 1,0,1,1,... in sequence. Required response:
  - Items 0-3 go to lane 0, items 4-7 to lane 1, items 8-11 to lane 2.
  - There is exactly one bubble cycle between bursts.
  - sel steps 0, 1, 2.
- lane_en=8'b1000_0001 with continuous input. Bursts alternate between lane 0 and lane 7, confirming wrap-around from 7 to 0.
- Hold out_ready[0]=0 for 5 cycles during lane 0's burst. Required response:
  - out_valid[0] stays high with out_data stable.
  - in_ready stays low.
  - The burst resumes with no item lost.
- Clear lane_en[0] while an item is held and lane 0 is not ready. Required response:
  - The next cycle is SEEK.
  - The held item is delivered to lane 1 with burst_cnt restarted.
- Set lane_en=0 with an item held. Required response:
  - State goes to IDLE, out_valid=0 and busy=1.
  - Re-enabling lane 3 delivers the held item to lane 3.
- Assert rst mid-burst. On the next edge all outputs are at reset values and hold_valid=0; with DEMUX_SCHED_STATS_EN defined, all counters are 0.
